// File: rtl/ebi_pkg.sv
// Shared definitions for the M2 off-die link receiver: header field
// offsets, default link geometry, message struct and FSM state types.
package ebi_pkg;

    localparam int EBI_OFF_DIE_WD = 32;
    localparam int EBI_CH_NUM     = 5;
    localparam int EBI_CH_NUM_W   = 3;
    localparam int EBI_MAX_BEATS  = 8;
    localparam int EBI_LEN_W      = 4;
    localparam int EBI_BEAT_W     = EBI_OFF_DIE_WD - 1;
    localparam int EBI_DATA_W     = EBI_MAX_BEATS * EBI_BEAT_W;

    // Header layout: channel id in the low bits, length right above it.
    localparam int EBI_HDR_CH_LSB  = 0;
    localparam int EBI_HDR_LEN_LSB = EBI_CH_NUM_W;

    typedef struct packed {
        logic [EBI_CH_NUM_W-1:0] ch;
        logic [EBI_LEN_W-1:0]    len;
        logic [EBI_DATA_W-1:0]   data;
    } ebi_msg_t;

    typedef enum logic {
        ASM_IDLE,
        ASM_PAYLOAD
    } asm_state_e;

    typedef enum logic {
        CR_INIT,
        CR_RUN
    } cr_state_e;

endpackage

// File: rtl/ebi_msg_fifo.sv
// Message FIFO of ebi_msg_t entries. A pop in the same cycle as a push
// frees the head slot first, so push is accepted even when full.
// Ports: clk/rst_n, push_i+push_msg_i, pop_i, valid_o, full_o, head_o
// (head_o is forced to zero while empty).
module ebi_msg_fifo
    import ebi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  ebi_msg_t push_msg_i,
    input  logic     pop_i,
    output logic     valid_o,
    output logic     full_o,
    output ebi_msg_t head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    ebi_msg_t        mem_q [DEPTH];
    ebi_msg_t        mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && valid_o;
        do_push = push_i && (!full_o || do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_msg_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m2_ebi_link_rx.sv
// M2 off-die link receiver: assembles header+payload beats into messages,
// queues them, and manages the credit loop back to the far-end sender.
// Ports: m2_clk, rst (async active-low), m1_m2_bus_i, m2_m1_credit_o,
// msg_valid_o/msg_ready_i handshake with msg_ch_o/msg_len_o/msg_data_o,
// err_o (bit0 protocol error, bit1 overflow, both sticky).
module m2_ebi_link_rx
    import ebi_pkg::*;
#(
    parameter int OFF_DIE_WD = EBI_OFF_DIE_WD,
    parameter int CH_NUM     = EBI_CH_NUM,
    parameter int CH_NUM_W   = EBI_CH_NUM_W,
    parameter int MAX_BEATS  = EBI_MAX_BEATS,
    parameter int MSG_DEPTH  = 4
) (
    input  logic                                 m2_clk,
    input  logic                                 rst,
    input  logic [OFF_DIE_WD-1:0]                m1_m2_bus_i,
    output logic                                 m2_m1_credit_o,
    output logic                                 msg_valid_o,
    input  logic                                 msg_ready_i,
    output logic [CH_NUM_W-1:0]                  msg_ch_o,
    output logic [3:0]                           msg_len_o,
    output logic [MAX_BEATS*(OFF_DIE_WD-1)-1:0]  msg_data_o,
    output logic [1:0]                           err_o
);

    localparam int BW = OFF_DIE_WD - 1;
    localparam int DW = MAX_BEATS * BW;
    localparam int CW = $clog2(MSG_DEPTH + 1);

    asm_state_e          asm_q, asm_d;
    cr_state_e           cr_q, cr_d;
    logic [CH_NUM_W-1:0] ch_q, ch_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DW-1:0]       buf_q, buf_d;
    logic [1:0]          err_q, err_d;
    logic [CW-1:0]       cr_cnt_q, cr_cnt_d;
    logic                credit_q, credit_d;

    logic                beat_vld;
    logic [CH_NUM_W-1:0] hdr_ch;
    logic [3:0]          hdr_len;
    logic                hdr_ok;
    logic                push;
    logic                pop;
    ebi_msg_t            push_msg;
    ebi_msg_t            head;
    logic                fifo_valid;
    logic                fifo_full;

    assign beat_vld = m1_m2_bus_i[OFF_DIE_WD-1];
    assign hdr_ch   = m1_m2_bus_i[EBI_HDR_CH_LSB +: CH_NUM_W];
    assign hdr_len  = m1_m2_bus_i[EBI_HDR_LEN_LSB +: 4];
    assign hdr_ok   = (hdr_len != 4'd0)
                   && ({1'b0, hdr_len} <= 5'(MAX_BEATS))
                   && ({1'b0, hdr_ch} < (CH_NUM_W+1)'(CH_NUM));

    assign pop = fifo_valid && msg_ready_i;

    always_comb begin
        asm_d = asm_q;
        ch_d  = ch_q;
        len_d = len_q;
        cnt_d = cnt_q;
        buf_d = buf_q;
        err_d = err_q;
        push  = 1'b0;
        unique case (asm_q)
            ASM_IDLE: begin
                if (beat_vld) begin
                    if (hdr_ok) begin
                        ch_d  = hdr_ch;
                        len_d = hdr_len;
                        cnt_d = '0;
                        buf_d = '0;
                        asm_d = ASM_PAYLOAD;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
            end
            ASM_PAYLOAD: begin
                if (beat_vld) begin
                    buf_d[cnt_q*BW +: BW] = m1_m2_bus_i[BW-1:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q - 4'd1) begin
                        push  = 1'b1;
                        asm_d = ASM_IDLE;
                    end
                end
            end
            default: asm_d = ASM_IDLE;
        endcase
        push_msg.ch   = ch_q;
        push_msg.len  = len_q;
        push_msg.data = buf_d;
        // A same-cycle pop makes room, so only a true full drops.
        if (push && fifo_full && !pop) begin
            err_d[1] = 1'b1;
        end
    end

    // Initial credits go out back to back; pop credits only once running.
    always_comb begin
        cr_d     = cr_q;
        cr_cnt_d = cr_cnt_q;
        credit_d = 1'b0;
        unique case (cr_q)
            CR_INIT: begin
                credit_d = 1'b1;
                cr_cnt_d = cr_cnt_q + 1'b1;
                if (cr_cnt_q == CW'(MSG_DEPTH - 1)) begin
                    cr_d = CR_RUN;
                end
            end
            CR_RUN:  credit_d = pop;
            default: cr_d = CR_INIT;
        endcase
    end

    always_ff @(posedge m2_clk or negedge rst) begin
        if (!rst) begin
            asm_q    <= ASM_IDLE;
            cr_q     <= CR_INIT;
            ch_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            err_q    <= '0;
            cr_cnt_q <= '0;
            credit_q <= 1'b0;
        end else begin
            asm_q    <= asm_d;
            cr_q     <= cr_d;
            ch_q     <= ch_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            err_q    <= err_d;
            cr_cnt_q <= cr_cnt_d;
            credit_q <= credit_d;
        end
    end

    ebi_msg_fifo #(
        .DEPTH (MSG_DEPTH)
    ) u_fifo (
        .clk        (m2_clk),
        .rst_n      (rst),
        .push_i     (push),
        .push_msg_i (push_msg),
        .pop_i      (pop),
        .valid_o    (fifo_valid),
        .full_o     (fifo_full),
        .head_o     (head)
    );

    assign m2_m1_credit_o = credit_q;
    assign msg_valid_o    = fifo_valid;
    assign msg_ch_o       = head.ch;
    assign msg_len_o      = head.len;
    assign msg_data_o     = head.data;
    assign err_o          = err_q;

endmodule

// File: tb/tb_m2_ebi_link_rx.sv
// Self-checking bench for m2_ebi_link_rx: vector table, corner-case
// sequences and a randomized run against a queue-based message model.
module tb_m2_ebi_link_rx;

    localparam int DW = 8 * 31;

    logic          clk;
    logic          rst_n;
    logic [31:0]   bus;
    logic          rdy;
    logic          credit;
    logic          vld;
    logic [2:0]    ch;
    logic [3:0]    len;
    logic [DW-1:0] data;
    logic [1:0]    err;

    int checks = 0;
    int errors = 0;

    m2_ebi_link_rx dut (
        .m2_clk         (clk),
        .rst            (rst_n),
        .m1_m2_bus_i    (bus),
        .m2_m1_credit_o (credit),
        .msg_valid_o    (vld),
        .msg_ready_i    (rdy),
        .msg_ch_o       (ch),
        .msg_len_o      (len),
        .msg_data_o     (data),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   bus;
        logic          rdy;
        logic          vld;
        logic [2:0]    ch;
        logic [3:0]    len;
        logic [DW-1:0] data;
        logic [1:0]    err;
        logic          cr;
    } vec_t;

    typedef struct {
        logic [2:0]    ch;
        logic [3:0]    len;
        logic [DW-1:0] data;
    } msg_t;

    vec_t tbl [14];

    msg_t          q [$];
    logic          m_in;
    int            m_idx;
    logic [2:0]    m_ch;
    logic [3:0]    m_len;
    logic [DW-1:0] m_data;
    logic [1:0]    m_err;

    function automatic vec_t mk(input logic [31:0] b, input logic r,
                                input logic v, input logic [2:0] c,
                                input logic [3:0] l, input logic [DW-1:0] d,
                                input logic [1:0] e, input logic cr);
        vec_t t;
        t.bus = b; t.rdy = r; t.vld = v; t.ch = c;
        t.len = l; t.data = d; t.err = e; t.cr = cr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus   = '0;
        rdy   = 1'b0;
        repeat (2) tick();
        chk("rst_credit", DW'(credit), '0);
        chk("rst_valid", DW'(vld), '0);
        chk("rst_ch", DW'(ch), '0);
        chk("rst_len", DW'(len), '0);
        chk("rst_data", data, '0);
        chk("rst_err", DW'(err), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("init_credit%0d", i), DW'(credit),
                DW'(i < 4 ? 1 : 0));
        end
        chk("init_valid", DW'(vld), '0);
        chk("init_err", DW'(err), '0);
    endtask

    task automatic send1(input logic [2:0] c, input logic [30:0] p);
        bus = {1'b1, 24'h0, 4'd1, c};
        tick();
        bus = {1'b1, p};
        tick();
        bus = '0;
    endtask

    initial begin
        logic [DW-1:0] d2;
        logic [DW-1:0] dab;
        d2  = (DW'(32'h5678) << 31) | DW'(32'h1234);
        dab = DW'(32'h0ABC);
        tbl[0]  = mk(32'h8000_0013, 0, 0, 0, 0, '0, 2'b00, 0);
        tbl[1]  = mk(32'h8000_1234, 0, 0, 0, 0, '0, 2'b00, 0);
        tbl[2]  = mk(32'h0000_5555, 0, 0, 0, 0, '0, 2'b00, 0);
        tbl[3]  = mk(32'h8000_5678, 0, 1, 3, 2, d2, 2'b00, 0);
        tbl[4]  = mk(32'h0000_0000, 0, 1, 3, 2, d2, 2'b00, 0);
        tbl[5]  = mk(32'h0000_0000, 1, 0, 0, 0, '0, 2'b00, 1);
        tbl[6]  = mk(32'h0000_0000, 0, 0, 0, 0, '0, 2'b00, 0);
        tbl[7]  = mk(32'h8000_0001, 0, 0, 0, 0, '0, 2'b01, 0);
        tbl[8]  = mk(32'h8000_000F, 0, 0, 0, 0, '0, 2'b01, 0);
        tbl[9]  = mk(32'h8000_0048, 0, 0, 0, 0, '0, 2'b01, 0);
        tbl[10] = mk(32'h8000_000C, 0, 0, 0, 0, '0, 2'b01, 0);
        tbl[11] = mk(32'h8000_0ABC, 0, 1, 4, 1, dab, 2'b01, 0);
        tbl[12] = mk(32'h0000_0000, 1, 0, 0, 0, '0, 2'b01, 1);
        tbl[13] = mk(32'h0000_0000, 0, 0, 0, 0, '0, 2'b01, 0);

        do_reset();

        for (int i = 0; i < 14; i++) begin
            bus = tbl[i].bus;
            rdy = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d_valid", i), DW'(vld), DW'(tbl[i].vld));
            chk($sformatf("v%0d_credit", i), DW'(credit), DW'(tbl[i].cr));
            chk($sformatf("v%0d_err", i), DW'(err), DW'(tbl[i].err));
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_ch", i), DW'(ch), DW'(tbl[i].ch));
                chk($sformatf("v%0d_len", i), DW'(len), DW'(tbl[i].len));
                chk($sformatf("v%0d_data", i), data, tbl[i].data);
            end
        end
        rdy = 1'b0;

        // Five messages into a four-deep queue with the consumer stalled.
        for (int i = 0; i < 5; i++) begin
            send1(3'(i), 31'(32'h100 + i));
        end
        tick();
        chk("ovf_valid", DW'(vld), 1);
        chk("ovf_err", DW'(err), DW'(2'b11));
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_ch", i), DW'(ch), DW'(i));
            chk($sformatf("drain%0d_len", i), DW'(len), 1);
            chk($sformatf("drain%0d_data", i), data, DW'(32'h100 + i));
            tick();
            chk($sformatf("drain%0d_credit", i), DW'(credit), 1);
        end
        rdy = 1'b0;
        chk("drain_empty", DW'(vld), 0);
        tick();
        chk("drain_credit_off", DW'(credit), 0);

        // Reset with one stored message and a half-built one.
        send1(3'd1, 31'h55);
        bus = 32'h8000_001A;
        tick();
        bus = 32'h8000_0011;
        tick();
        bus = '0;
        chk("pre_rst_valid", DW'(vld), 1);
        do_reset();
        send1(3'd2, 31'h77);
        tick();
        chk("post_rst_valid", DW'(vld), 1);
        chk("post_rst_ch", DW'(ch), 2);
        chk("post_rst_data", data, DW'(32'h77));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("post_rst_credit", DW'(credit), 1);
        chk("post_rst_empty", DW'(vld), 0);

        // Randomized run against the message-level model.
        do_reset();
        q.delete();
        m_in   = 1'b0;
        m_idx  = 0;
        m_ch   = '0;
        m_len  = '0;
        m_data = '0;
        m_err  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic bv;
            logic pop;
            logic popped;
            bv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            if (!m_in) begin
                logic [2:0] hc;
                logic [3:0] hl;
                if ($urandom_range(0, 99) < 85) begin
                    hc = 3'($urandom_range(0, 4));
                    hl = 4'($urandom_range(1, 8));
                end else begin
                    hc = 3'($urandom);
                    hl = 4'($urandom);
                end
                bus = {bv, 24'($urandom), hl, hc};
            end else begin
                bus = {bv, 31'($urandom)};
            end

            pop    = (q.size() > 0) && rdy;
            popped = 1'b0;
            if (bus[31]) begin
                if (!m_in) begin
                    if (bus[2:0] < 5 && bus[6:3] >= 1 && bus[6:3] <= 8) begin
                        m_in   = 1'b1;
                        m_ch   = bus[2:0];
                        m_len  = bus[6:3];
                        m_idx  = 0;
                        m_data = '0;
                    end else begin
                        m_err[0] = 1'b1;
                    end
                end else begin
                    m_data[m_idx*31 +: 31] = bus[30:0];
                    m_idx++;
                    if (m_idx == int'(m_len)) begin
                        msg_t m;
                        m_in = 1'b0;
                        if (pop) begin
                            void'(q.pop_front());
                            popped = 1'b1;
                        end
                        if (q.size() < 4) begin
                            m.ch = m_ch; m.len = m_len; m.data = m_data;
                            q.push_back(m);
                        end else begin
                            m_err[1] = 1'b1;
                        end
                    end
                end
            end
            if (pop && !popped) begin
                void'(q.pop_front());
            end

            tick();
            chk("rnd_valid", DW'(vld), DW'(q.size() != 0));
            chk("rnd_credit", DW'(credit), DW'(pop));
            chk("rnd_err", DW'(err), DW'(m_err));
            if (q.size() != 0) begin
                chk("rnd_ch", DW'(ch), DW'(q[0].ch));
                chk("rnd_len", DW'(len), DW'(q[0].len));
                chk("rnd_data", data, q[0].data);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
